// File: rtl/sha3_padder.sv
// sha3_padder
// Byte-stream front end for the SHA3-256 core. Collects message bytes into a
// rate block, applies SHA3 padding (0x06 ... 0x80), and hands each block to
// the core, pacing non-first blocks on the core's hash_next.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   din[7:0]            message byte
//   din_valid           beat valid
//   din_keep            beat carries a byte (0 only with din_last)
//   din_last            final beat of the message
//   din_ready           beat accepted when din_valid & din_ready
//   block[8*RATE_BYTES-1:0]  rate block to core `in`
//   blk_valid           one-cycle pulse to core `in_valid`
//   blk_more            further blocks follow, to core `more`
//   hash_next           core ready for the next block of the same message
//   core_done           core digest present (core `out_valid`)
//
// state     | meaning
// S_FILL    | accepting message bytes into the buffer
// S_PAD     | one cycle: XOR 0x06 at byte cnt and 0x80 at the last byte
// S_ISSUE   | waiting for permission, then one blk_valid pulse
// S_WAIT    | final block issued, wait for the digest
module sha3_padder #(
  parameter int RATE_BYTES = 136
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              din,
  input  logic                    din_valid,
  input  logic                    din_keep,
  input  logic                    din_last,
  output logic                    din_ready,
  output logic [8*RATE_BYTES-1:0] block,
  output logic                    blk_valid,
  output logic                    blk_more,
  input  logic                    hash_next,
  input  logic                    core_done
);

  localparam int BW = 8 * RATE_BYTES;
  localparam int CW = $clog2(RATE_BYTES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(RATE_BYTES - 1);

  typedef enum logic [1:0] {S_FILL, S_PAD, S_ISSUE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          first_q, first_d;
  logic          pad_only_q, pad_only_d;
  logic          more_q, more_d;
  logic          hn_q, hn_d;
  logic          valid_q, valid_d;
  logic          wr_en, pad_en, clr;
  logic [7:0]    data_q [RATE_BYTES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FILL;
      cnt_q      <= '0;
      first_q    <= 1'b1;
      pad_only_q <= 1'b0;
      more_q     <= 1'b0;
      hn_q       <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      pad_only_q <= pad_only_d;
      more_q     <= more_d;
      hn_q       <= hn_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    pad_only_d = pad_only_q;
    more_d     = more_q;
    valid_d    = 1'b0;
    // hash_next is captured in any state so an early one survives until issue
    hn_d       = hn_q | hash_next;
    wr_en      = 1'b0;
    pad_en     = 1'b0;
    clr        = 1'b0;
    din_ready  = (state_q == S_FILL);

    case (state_q)
      S_FILL: begin
        if (din_valid) begin
          if (din_keep) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + CW'(1);
          end
          if (din_keep && cnt_q == LAST_IDX) begin
            // Block full: padding (if this was the last byte) needs a block of its own.
            state_d    = S_ISSUE;
            more_d     = 1'b1;
            pad_only_d = din_last;
            valid_d    = first_q;
          end else if (din_last) begin
            state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        pad_en  = 1'b1;
        more_d  = 1'b0;
        state_d = S_ISSUE;
        valid_d = first_q;
      end
      S_ISSUE: begin
        if (valid_q) begin
          // Pulse is on the bus this cycle; hash_next now refers to this block.
          clr     = 1'b1;
          first_d = 1'b0;
          hn_d    = 1'b0;
          cnt_d   = '0;
          if (more_q && pad_only_q) begin
            state_d    = S_PAD;
            pad_only_d = 1'b0;
          end else if (more_q) begin
            state_d = S_FILL;
          end else begin
            state_d = S_WAIT;
          end
        end else if (first_q || hn_q || hash_next) begin
          valid_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (core_done) begin
          state_d = S_FILL;
          first_d = 1'b1;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RATE_BYTES; i++) data_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < RATE_BYTES; i++) data_q[i] <= '0;
    end else if (wr_en) begin
      data_q[cnt_q] <= din;
    end else if (pad_en) begin
      // Both pad bytes can land on the last byte; merge them into one write.
      if (cnt_q == LAST_IDX) begin
        data_q[RATE_BYTES-1] <= data_q[RATE_BYTES-1] ^ 8'h86;
      end else begin
        data_q[cnt_q]        <= data_q[cnt_q] ^ 8'h06;
        data_q[RATE_BYTES-1] <= data_q[RATE_BYTES-1] ^ 8'h80;
      end
    end
  end

  // Byte k bit j sits at block[BW-1-8k-j]: bytes MSB-first, bits LSB-first.
  always_comb begin
    block = '0;
    for (int k = 0; k < RATE_BYTES; k++) begin
      for (int j = 0; j < 8; j++) begin
        block[BW-1-8*k-j] = data_q[k][j];
      end
    end
  end

  assign blk_valid = valid_q;
  assign blk_more  = more_q;

endmodule

// File: tb/tb_sha3_padder.sv
module tb_sha3_padder;
  localparam int RB = 136;
  localparam int BW = 8 * RB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    din = '0;
  logic          din_valid = 1'b0, din_keep = 1'b0, din_last = 1'b0;
  logic          din_ready;
  logic [BW-1:0] block;
  logic          blk_valid, blk_more;
  logic          hash_next = 1'b0, core_done = 1'b0;

  sha3_padder #(.RATE_BYTES(RB)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_keep(din_keep), .din_last(din_last), .din_ready(din_ready),
    .block(block), .blk_valid(blk_valid), .blk_more(blk_more),
    .hash_next(hash_next), .core_done(core_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [BW-1:0] blk;
    logic          more;
    logic          first;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [BW-1:0] got_blk[$];
  logic          got_more[$];
  int            got_cyc[$];
  int            hn_cyc[$];
  int            acc_cyc[$];
  logic [7:0]    msg[$];
  int            n_chk = 0, n_err = 0;
  int            hn_delay = 10;
  int            hn_cnt = 0, cd_cnt = 0;
  bit            hn_since = 0, in_wait = 0, prev_valid = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [BW-1:0] b, input int k);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = b[BW-1-8*k-j];
    return r;
  endfunction

  task automatic chk_blk(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      int k;
      n_err++;
      k = 0;
      while (k < RB - 1 && byte_of(got, k) === byte_of(exp, k)) k++;
      $display("FAIL %s: byte %0d got=%02h expected=%02h", nm, k, byte_of(got, k), byte_of(exp, k));
    end
  endtask

  // Padded message = msg || 0x06 || 0.. || 0x80 (XORed when they coincide),
  // split into RB-byte blocks.
  function automatic void model_push();
    int n, len, nb;
    logic [7:0] p[];
    exp_t e;
    n   = msg.size();
    len = (n / RB + 1) * RB;
    nb  = len / RB;
    p   = new[len];
    for (int i = 0; i < len; i++) p[i] = 8'h00;
    for (int i = 0; i < n; i++) p[i] = msg[i];
    p[n]       = p[n] ^ 8'h06;
    p[len-1]   = p[len-1] ^ 8'h80;
    for (int b = 0; b < nb; b++) begin
      e.blk = '0;
      for (int k = 0; k < RB; k++)
        for (int j = 0; j < 8; j++)
          e.blk[BW-1-8*k-j] = p[b*RB+k][j];
      e.more  = (b < nb - 1);
      e.first = (b == 0);
      exp_q.push_back(e);
    end
  endfunction

  // Compare process plus a simple core stand-in driving hash_next/core_done.
  always @(negedge clk) begin
    if (!rst_n) begin
      hn_cnt = 0; cd_cnt = 0; hash_next = 1'b0; core_done = 1'b0;
      hn_since = 0; in_wait = 0; prev_valid = 0;
    end else begin
      if (in_wait) chk("din_ready_low_until_done", 32'(din_ready), 0);
      if (blk_valid) begin
        chk("no_back_to_back_valid", 32'(prev_valid), 0);
        got_blk.push_back(block);
        got_more.push_back(blk_more);
        got_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_block: got block at cycle %0d expected none", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk_blk("block_vs_model", block, mon_e.blk);
          chk("blk_more_vs_model", 32'(blk_more), 32'(mon_e.more));
          if (!mon_e.first) chk("hash_next_seen_before_issue", 32'(hn_since), 1);
        end
        hn_since = 0;
      end
      prev_valid = blk_valid;
      hash_next = 1'b0;
      core_done = 1'b0;
      if (hn_cnt > 0) begin
        hn_cnt--;
        if (hn_cnt == 0) begin
          hash_next = 1'b1; hn_since = 1; hn_cyc.push_back(cyc);
        end
      end
      if (cd_cnt > 0) begin
        cd_cnt--;
        if (cd_cnt == 0) begin
          core_done = 1'b1; in_wait = 0;
        end
      end
      if (blk_valid) begin
        if (blk_more) hn_cnt = hn_delay;
        else begin cd_cnt = 5; in_wait = 1; end
      end
    end
  end

  task automatic wait_ready();
    int g = 0;
    while (!din_ready && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (!din_ready) begin
      n_chk++; n_err++;
      $display("FAIL din_ready_timeout: got=0 expected=1");
    end
  endtask

  // Called at a negedge; drives one beat per accept.
  task automatic drive_bytes(input int cnt, input bit with_last);
    acc_cyc.delete();
    if (cnt == 0) begin
      din = 8'h00; din_keep = 1'b0; din_last = 1'b1; din_valid = 1'b1;
      wait_ready();
      acc_cyc.push_back(cyc);
      @(negedge clk);
      chk("din_ready_fall_empty", 32'(din_ready), 0);
    end
    for (int i = 0; i < cnt; i++) begin
      din = msg[i]; din_keep = 1'b1; din_valid = 1'b1;
      din_last = with_last && (i == cnt - 1);
      wait_ready();
      acc_cyc.push_back(cyc);
      @(negedge clk);
      if ((with_last && i == cnt - 1) || (i % RB == RB - 1))
        chk("din_ready_fall", 32'(din_ready), 0);
    end
    din_valid = 1'b0; din_last = 1'b0; din_keep = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((exp_q.size() != 0 || in_wait || !din_ready) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) begin
      n_chk++; n_err++;
      $display("FAIL idle_timeout: got pending=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic start_test();
    got_blk.delete(); got_more.delete(); got_cyc.delete();
    hn_cyc.delete(); msg.delete();
  endtask

  task automatic run_msg(input int n);
    model_push();
    drive_bytes(n, 1'b1);
    wait_idle();
  endtask

  logic [BW-1:0] lit;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_din_ready", 32'(din_ready), 1);
    chk("rst_blk_valid", 32'(blk_valid), 0);
    chk("rst_blk_more", 32'(blk_more), 0);
    chk_blk("rst_block", block, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Empty message
    start_test(); hn_delay = 10;
    run_msg(0);
    chk("empty_nblocks", 32'(got_blk.size()), 1);
    if (got_blk.size() >= 1) begin
      lit = '0; lit[1086] = 1'b1; lit[1085] = 1'b1; lit[0] = 1'b1;
      chk_blk("empty_literal", got_blk[0], lit);
      chk("empty_more", 32'(got_more[0]), 0);
      chk("empty_latency", 32'(got_cyc[0] - acc_cyc[0]), 2);
    end

    // "abc"
    start_test();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    run_msg(3);
    chk("abc_nblocks", 32'(got_blk.size()), 1);
    if (got_blk.size() >= 1) begin
      chk("abc_bit1087", 32'(got_blk[0][1087]), 1);
      chk("abc_bit1082", 32'(got_blk[0][1082]), 1);
      chk("abc_bit1081", 32'(got_blk[0][1081]), 1);
      chk("abc_bit1086", 32'(got_blk[0][1086]), 0);
      chk("abc_byte3", 32'(byte_of(got_blk[0], 3)), 'h06);
      chk("abc_byte135", 32'(byte_of(got_blk[0], 135)), 'h80);
      chk("abc_latency", 32'(got_cyc[0] - acc_cyc[2]), 2);
    end

    // 135 bytes: pad bytes merge into 0x86
    start_test();
    for (int i = 0; i < 135; i++) msg.push_back(8'((i * 37 + 5) % 255 + 1));
    run_msg(135);
    chk("b135_nblocks", 32'(got_blk.size()), 1);
    if (got_blk.size() >= 1) begin
      chk("b135_byte135", 32'(byte_of(got_blk[0], 135)), 'h86);
      chk("b135_byte134", 32'(byte_of(got_blk[0], 134)), 32'(msg[134]));
      chk("b135_more", 32'(got_more[0]), 0);
    end

    // 136 bytes: padding-only second block gated by hash_next
    start_test(); hn_delay = 10;
    for (int i = 0; i < 136; i++) msg.push_back(8'((i * 11 + 3) % 255 + 1));
    run_msg(136);
    chk("b136_nblocks", 32'(got_blk.size()), 2);
    if (got_blk.size() >= 2 && hn_cyc.size() >= 1) begin
      chk("b136_more1", 32'(got_more[0]), 1);
      chk("b136_lat1", 32'(got_cyc[0] - acc_cyc[135]), 1);
      chk("b136_b2_byte0", 32'(byte_of(got_blk[1], 0)), 'h06);
      chk("b136_b2_byte135", 32'(byte_of(got_blk[1], 135)), 'h80);
      chk("b136_more2", 32'(got_more[1]), 0);
      chk("b136_lat2_after_hn", 32'(got_cyc[1] - hn_cyc[0]), 1);
    end

    // 300 bytes, hash_next 50 cycles after each non-final issue
    start_test(); hn_delay = 50;
    for (int i = 0; i < 300; i++) msg.push_back(8'((i * 29 + 7) % 255 + 1));
    run_msg(300);
    chk("b300_nblocks", 32'(got_blk.size()), 3);
    if (got_blk.size() >= 3 && hn_cyc.size() >= 2) begin
      chk("b300_lat2_held_hn", 32'(got_cyc[1] - acc_cyc[271]), 2);
      chk("b300_lat3_after_hn", 32'(got_cyc[2] - hn_cyc[1]), 1);
      chk("b300_b3_byte28", 32'(byte_of(got_blk[2], 28)), 'h06);
      chk("b300_b3_byte27", 32'(byte_of(got_blk[2], 27)), 32'(msg[299]));
      chk("b300_more", 32'({got_more[0], got_more[1], got_more[2]}), 'b110);
    end

    // Reset in the middle of a block, then a short message
    start_test(); hn_delay = 10;
    for (int i = 0; i < 70; i++) msg.push_back(8'((i * 13 + 9) % 255 + 1));
    drive_bytes(70, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_din_ready", 32'(din_ready), 1);
    chk("midrst_blk_valid", 32'(blk_valid), 0);
    chk("midrst_blk_more", 32'(blk_more), 0);
    chk_blk("midrst_block", block, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    start_test();
    msg.push_back(8'h11); msg.push_back(8'h22); msg.push_back(8'h33);
    run_msg(3);
    chk("postrst_nblocks", 32'(got_blk.size()), 1);
    if (got_blk.size() >= 1) begin
      chk("postrst_byte0", 32'(byte_of(got_blk[0], 0)), 'h11);
      chk("postrst_byte3", 32'(byte_of(got_blk[0], 3)), 'h06);
      chk("postrst_byte4_no_stale", 32'(byte_of(got_blk[0], 4)), 0);
      chk("postrst_byte69_no_stale", 32'(byte_of(got_blk[0], 69)), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
